interrupt_ctrl: RTL and testbench

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_sync.sv | 27 ++
 rtl/interrupt_ctrl.sv | 103 ++++++++++
 tb/tb_interrupt_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller:
// FSM state encoding, mcause values and mip bit positions.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } irq_state_e;

    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;

    function automatic logic [31:0] mip_pack(input logic mtip, input logic meip);
        logic [31:0] v;
        v           = '0;
        v[MTIP_BIT] = mtip;
        v[MEIP_BIT] = meip;
        return v;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt line.
// Only compiled when IRQ_EXT_SYNC_EN is defined, since nothing else uses it.
`ifdef IRQ_EXT_SYNC_EN
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule
`endif

// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt controller: waits for MW to drain, then raises a one-cycle trap.
// Define IRQ_EXT_SYNC_EN to pass External_Intrpt through a 2-flop synchronizer.
module interrupt_ctrl
    import irq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Timer_Intrpt,
    input  logic        External_Intrpt,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        Stall_MW,
    input  logic        mret_MW,
    input  logic [31:0] pc_DE,
    output logic        trap_req,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_epc,
    output logic        flush,
    output logic [31:0] mip_out
);

    logic       meip;
    logic       mtip;
    logic       ext_take;
    logic       take;
    logic       latch_en;
    irq_state_e state;
    irq_state_e state_nxt;

`ifdef IRQ_EXT_SYNC_EN
    irq_sync u_ext_sync (
        .clk (clk),
        .rst (rst),
        .d   (External_Intrpt),
        .q   (meip)
    );
`else
    assign meip = External_Intrpt;
`endif

    assign mtip     = Timer_Intrpt;
    assign ext_take = mie_meie & meip;
    assign take     = mstatus_mie & (ext_take | (mie_mtie & mtip));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An mret retiring this cycle would race the mepc write, so entry waits a cycle.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                if (take && !mret_MW) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!take) begin
                    state_nxt = IDLE;
                end else if (!Stall_MW) begin
                    state_nxt = TRAP;
                    latch_en  = 1'b1;
                end
            end
            TRAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Cause is chosen at the drain exit so a late external interrupt still wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_cause <= '0;
            trap_epc   <= '0;
        end else if (latch_en) begin
            trap_cause <= ext_take ? CAUSE_MEI : CAUSE_MTI;
            trap_epc   <= pc_DE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mip_out <= '0;
        end else begin
            mip_out <= mip_pack(mtip, meip);
        end
    end

    assign trap_req = (state == TRAP);
    assign flush    = (state == TRAP);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: stimulus pushes expected traps, a negedge monitor checks them.
module tb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        Timer_Intrpt;
    logic        External_Intrpt;
    logic        mstatus_mie;
    logic        mie_mtie;
    logic        mie_meie;
    logic        Stall_MW;
    logic        mret_MW;
    logic [31:0] pc_DE;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic        flush;
    logic [31:0] mip_out;

    typedef struct {
        int          cyc;
        logic [31:0] cause;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] MTI = 32'h8000_0007;
    localparam logic [31:0] MEI = 32'h8000_000B;

    interrupt_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .Timer_Intrpt    (Timer_Intrpt),
        .External_Intrpt (External_Intrpt),
        .mstatus_mie     (mstatus_mie),
        .mie_mtie        (mie_mtie),
        .mie_meie        (mie_meie),
        .Stall_MW        (Stall_MW),
        .mret_MW         (mret_MW),
        .pc_DE           (pc_DE),
        .trap_req        (trap_req),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc),
        .flush           (flush),
        .mip_out         (mip_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [31:0] cause, input logic [31:0] epc);
        exp_t e;
        e.cyc   = c;
        e.cause = cause;
        e.epc   = epc;
        exp_q.push_back(e);
    endtask

    task automatic quiet();
        Timer_Intrpt    = 1'b0;
        External_Intrpt = 1'b0;
        mstatus_mie     = 1'b0;
        mie_mtie        = 1'b0;
        mie_meie        = 1'b0;
        Stall_MW        = 1'b0;
        mret_MW         = 1'b0;
    endtask

    // Monitor: flush must track trap_req; every trap must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        check("flush_eq_trap_req", {31'd0, flush}, {31'd0, trap_req});
        if (trap_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_trap cyc=%0d actual cause=0x%08h required no trap", cyc, trap_cause);
            end else begin
                e = exp_q.pop_front();
                check("trap_cycle", cyc, e.cyc);
                check("trap_cause", trap_cause, e.cause);
                check("trap_epc", trap_epc, e.epc);
            end
        end
    end

    initial begin
        int n;
        rst   = 1'b1;
        pc_DE = 32'h0;
        quiet();
        tick(1);
        // Pending, enabled interrupt held in reset must not show up anywhere.
        Timer_Intrpt = 1'b1;
        mstatus_mie  = 1'b1;
        mie_mtie     = 1'b1;
        tick(2);
        check("rst_trap_req", {31'd0, trap_req}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_cause", trap_cause, 32'd0);
        check("rst_epc", trap_epc, 32'd0);
        check("rst_mip", mip_out, 32'd0);
        quiet();
        rst = 1'b0;
        tick(2);
        check("idle_mip", mip_out, 32'd0);

        // Timer interrupt, no stall: trap two cycles after take rises.
        n = cyc;
        mstatus_mie  = 1'b1;
        mie_mtie     = 1'b1;
        Timer_Intrpt = 1'b1;
        pc_DE        = 32'h100;
        push(n + 2, MTI, 32'h100);
        tick(1);
        check("mip_timer", mip_out, 32'h0000_0080);
        tick(1);
        quiet();
        tick(1);
        check("hold_cause", trap_cause, MTI);
        check("hold_epc", trap_epc, 32'h100);
        tick(2);

        // Both pending and enabled: external wins, single trap.
        n = cyc;
        mstatus_mie     = 1'b1;
        mie_mtie        = 1'b1;
        mie_meie        = 1'b1;
        Timer_Intrpt    = 1'b1;
        External_Intrpt = 1'b1;
        pc_DE           = 32'h140;
        push(n + 2, MEI, 32'h140);
        tick(2);
        quiet();
        tick(3);

        // External pending but not enabled: timer cause.
        n = cyc;
        mstatus_mie     = 1'b1;
        mie_mtie        = 1'b1;
        Timer_Intrpt    = 1'b1;
        External_Intrpt = 1'b1;
        pc_DE           = 32'h500;
        push(n + 2, MTI, 32'h500);
        tick(2);
        quiet();
        tick(3);

        // Drain: Stall_MW high for 5 cycles, trap the cycle after it falls.
        n = cyc;
        mstatus_mie  = 1'b1;
        mie_mtie     = 1'b1;
        Timer_Intrpt = 1'b1;
        Stall_MW     = 1'b1;
        pc_DE        = 32'h1F0;
        push(n + 6, MTI, 32'h200);
        tick(5);
        Stall_MW = 1'b0;
        pc_DE    = 32'h200;
        tick(1);
        quiet();
        tick(3);

        // Masked globally: pending bits visible, no trap.
        mie_mtie        = 1'b1;
        mie_meie        = 1'b1;
        Timer_Intrpt    = 1'b1;
        External_Intrpt = 1'b1;
        tick(1);
        check("mip_masked", mip_out, 32'h0000_0880);
        tick(4);
        check("mip_masked_hold", mip_out, 32'h0000_0880);
        quiet();
        tick(1);
        check("mip_cleared", mip_out, 32'd0);
        tick(1);

        // mret collision: entry delayed by one cycle.
        n = cyc;
        mstatus_mie  = 1'b1;
        mie_mtie     = 1'b1;
        Timer_Intrpt = 1'b1;
        mret_MW      = 1'b1;
        pc_DE        = 32'h300;
        push(n + 3, MTI, 32'h300);
        tick(1);
        mret_MW = 1'b0;
        tick(2);
        quiet();
        tick(3);

        // Reset mid-DRAIN aborts; take still high after release traps normally.
        n = cyc;
        mstatus_mie  = 1'b1;
        mie_mtie     = 1'b1;
        Timer_Intrpt = 1'b1;
        Stall_MW     = 1'b1;
        pc_DE        = 32'h400;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_drain_trap_req", {31'd0, trap_req}, 32'd0);
        check("rst_drain_cause", trap_cause, 32'd0);
        check("rst_drain_epc", trap_epc, 32'd0);
        Stall_MW = 1'b0;
        pc_DE    = 32'h480;
        push(n + 5, MTI, 32'h480);
        tick(2);
        quiet();
        tick(3);

        // Interrupt withdrawn while draining: no trap, outputs hold.
        mstatus_mie     = 1'b1;
        mie_meie        = 1'b1;
        External_Intrpt = 1'b1;
        Stall_MW        = 1'b1;
        pc_DE           = 32'h700;
        tick(1);
        External_Intrpt = 1'b0;
        Stall_MW        = 1'b0;
        tick(4);
        check("withdrawn_cause_hold", trap_cause, MTI);
        check("withdrawn_epc_hold", trap_epc, 32'h480);
        quiet();
        tick(2);

        // External arrives during DRAIN: cause picked at drain exit.
        n = cyc;
        mstatus_mie  = 1'b1;
        mie_mtie     = 1'b1;
        Timer_Intrpt = 1'b1;
        Stall_MW     = 1'b1;
        pc_DE        = 32'h600;
        push(n + 2, MEI, 32'h610);
        tick(1);
        mie_meie        = 1'b1;
        External_Intrpt = 1'b1;
        Stall_MW        = 1'b0;
        pc_DE           = 32'h610;
        tick(1);
        quiet();
        tick(4);

        check("pending_traps_left", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
